// File: rtl/rr_token_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_token_arbiter_pkg
// Shared types and helpers for the round-robin token arbiter.
//   state_e        : arbiter FSM states (IDLE, GRANT)
//   MAX_N          : widest requester vector the helper functions accept
//   rotl1()        : rotate an n-bit one-hot vector left by one, wrapping
//   onehot_to_idx(): binary index of the set bit of a one-hot vector
// -----------------------------------------------------------------------------
package rr_token_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Helpers work on a fixed-width container so they can live in the package;
  // callers zero-extend into it and slice the low N bits back out.
  localparam int MAX_N = 32;

  // Rotate the low n bits of v up by one; bit n-1 wraps to bit 0.
  function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v,
                                             input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) r[(i + 1) % n] = v[i];
    end
    return r;
  endfunction

  // Index of the set bit; 0 for an all-zero vector.
  function automatic int onehot_to_idx(input logic [MAX_N-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_token_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_token_arbiter_if
// Request/grant bundle between N requesters and the arbiter.
//   req       : level request per requester (requesters -> arbiter)
//   gnt       : registered one-hot grant, zero when idle
//   gnt_valid : |gnt, registered
//   gnt_id    : binary index of the granted requester, holds when idle
//   token     : one-hot priority pointer for the next arbitration
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface rr_token_arbiter_if #(
  parameter int N = 4
);

  logic [N-1:0]         req;
  logic [N-1:0]         gnt;
  logic                 gnt_valid;
  logic [$clog2(N)-1:0] gnt_id;
  logic [N-1:0]         token;

  modport master (
    output req,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  token
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output token
  );

endinterface

// File: rtl/rr_token_arbiter_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner search. Starting at the index marked by
// the one-hot token, scans upward and wraps to 0; the first set request wins.
//   req_i     : request vector
//   token_i   : one-hot priority pointer
//   win_oh_o  : one-hot winner (zero when no request)
//   win_idx_o : binary winner index (zero when no request)
//   any_o     : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
  import rr_token_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [N-1:0]         token_i,
  output logic [N-1:0]         win_oh_o,
  output logic [$clog2(N)-1:0] win_idx_o,
  output logic                 any_o
);

  localparam int IW = $clog2(N);

  assign any_o = |req_i;

  always_comb begin
    int   p;
    int   cand;
    logic found;
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves a value unassigned, which would infer a latch.
    p         = onehot_to_idx(MAX_N'(token_i));
    cand      = 0;
    found     = 1'b0;
    win_oh_o  = '0;
    win_idx_o = '0;
    for (int i = 0; i < N; i++) begin
      cand = (p + i) % N;
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        win_oh_o[cand]  = 1'b1;
        win_idx_o       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/rr_token_arbiter.sv
// -----------------------------------------------------------------------------
// rr_token_arbiter
// Round-robin arbiter for one shared resource among N requesters. A one-hot
// token marks the highest-priority index; a grant is held while the winner
// keeps requesting, for at most MAX_HOLD cycles, then forcibly released.
// Every release is followed by one idle cycle before the next arbitration.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   arb_if : slave side of rr_token_arbiter_if (req in; gnt, gnt_valid,
//            gnt_id, token out, all registered)
// -----------------------------------------------------------------------------
module rr_token_arbiter
  import rr_token_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  rr_token_arbiter_if.slave    arb_if
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [0:0] S_IDLE  = 1'(IDLE);
  localparam logic [0:0] S_GRANT = 1'(GRANT);

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic [N-1:0]  token_q, token_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [N-1:0]     win_oh;
  logic [IW-1:0]    win_idx;
  logic             any_req;
  logic [MAX_N-1:0] token_rot;
  logic             release_grant;

  rr_pick #(.N(N)) u_pick (
    .req_i     (arb_if.req),
    .token_i   (token_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .any_o     (any_req)
  );

  // Next token points just past the winner, so the winner has lowest
  // priority at the following arbitration.
  assign token_rot = rotl1(MAX_N'(win_oh), N);

  // Other requesters are not looked at here: only the owner's request and
  // the hold budget decide when the grant ends.
  assign release_grant = !arb_if.req[gnt_id_q] || (hold_q == HW'(MAX_HOLD));

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    token_d     = token_q;
    hold_d      = hold_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d     = S_GRANT;
          gnt_d       = win_oh;
          gnt_valid_d = 1'b1;
          gnt_id_d    = win_idx;
          token_d     = token_rot[N-1:0];
          hold_d      = HW'(1);
        end
      end
      S_GRANT: begin
        if (release_grant) begin
          // gnt_id and token are kept; the idle cycle that follows is the
          // bubble before the next arbitration.
          state_d     = S_IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          hold_d      = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d     = S_IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        hold_d      = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      token_q     <= N'(1);
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      token_q     <= token_d;
      hold_q      <= hold_d;
    end
  end

  assign arb_if.gnt       = gnt_q;
  assign arb_if.gnt_valid = gnt_valid_q;
  assign arb_if.gnt_id    = gnt_id_q;
  assign arb_if.token     = token_q;

endmodule

// File: tb/tb_rr_token_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_token_arbiter
// Directed scenarios followed by randomized requests, all compared each cycle
// against a reference model that tracks owner, hold count and priority index
// as plain integers.
// -----------------------------------------------------------------------------
module tb_rr_token_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic rst;

  rr_token_arbiter_if #(.N(N)) arb_if ();

  rr_token_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) u_dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .arb_if (arb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state.
  bit m_granted;
  int m_owner;
  int m_held;
  int m_ptr;
  int m_gid;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
  endtask

  function automatic int exp_gnt();
    return m_granted ? (1 << m_owner) : 0;
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic rs);
    if (rs) begin
      m_granted = 0; m_owner = 0; m_held = 0; m_ptr = 0; m_gid = 0;
    end else if (!m_granted) begin
      if (r != '0) begin
        int w;
        w = -1;
        for (int i = 0; i < N; i++) begin
          if (w < 0 && r[(m_ptr + i) % N]) w = (m_ptr + i) % N;
        end
        m_granted = 1; m_owner = w; m_gid = w; m_held = 1;
        m_ptr = (w + 1) % N;
      end
    end else if (!r[m_owner] || m_held == MAX_HOLD) begin
      m_granted = 0; m_held = 0;
    end else begin
      m_held++;
    end
  endtask

  // Apply inputs, clock one edge, then compare every output with the model.
  task automatic step(input logic [N-1:0] r, input logic rs);
    arb_if.req = r;
    rst        = rs;
    @(posedge clk);
    model_edge(r, rs);
    cyc++;
    #1;
    check("gnt",       32'(arb_if.gnt),       32'(exp_gnt()));
    check("gnt_valid", 32'(arb_if.gnt_valid), 32'(m_granted));
    check("gnt_id",    32'(arb_if.gnt_id),    32'(m_gid));
    check("token",     32'(arb_if.token),     32'(1 << m_ptr));
  endtask

  logic [N-1:0] rq;
  logic [N-1:0] grant_seq [5];
  logic [N-1:0] token_seq [5];

  initial begin
    arb_if.req = '0;
    rst        = 1'b1;
    m_granted = 0; m_owner = 0; m_held = 0; m_ptr = 0; m_gid = 0;

    // Reset with all requests high.
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    check("rst_gnt",   32'(arb_if.gnt),       32'h0);
    check("rst_valid", 32'(arb_if.gnt_valid), 32'h0);
    check("rst_id",    32'(arb_if.gnt_id),    32'h0);
    check("rst_token", 32'(arb_if.token),     32'h1);

    // Single short request.
    step(4'b0001, 1'b0);
    check("short_gnt",   32'(arb_if.gnt),   32'h1);
    check("short_token", 32'(arb_if.token), 32'h2);
    step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    check("short_rel", 32'(arb_if.gnt), 32'h0);
    step(4'b0000, 1'b0);

    // All requesters held: grants at edges 1,6,11,16,21 after reset.
    grant_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    token_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    step(4'b0000, 1'b1);
    for (int e = 1; e <= 21; e++) begin
      step(4'b1111, 1'b0);
      if ((e - 1) % 5 == 0) begin
        check("order_gnt",   32'(arb_if.gnt),   32'(grant_seq[(e - 1) / 5]));
        check("order_token", 32'(arb_if.token), 32'(token_seq[(e - 1) / 5]));
      end else if ((e - 1) % 5 == 4) begin
        check("order_bubble", 32'(arb_if.gnt), 32'h0);
      end
    end

    // Wrap search: move token to 0100, then request 0011.
    step(4'b0000, 1'b0);
    step(4'b0010, 1'b0);
    check("wrap_pre_token", 32'(arb_if.token), 32'h4);
    step(4'b0000, 1'b0);
    step(4'b0011, 1'b0);
    check("wrap_gnt",   32'(arb_if.gnt),    32'h1);
    check("wrap_id",    32'(arb_if.gnt_id), 32'h0);
    check("wrap_token", 32'(arb_if.token),  32'h2);

    // Handover: owner 0 drops as requester 2 raises.
    step(4'b0100, 1'b0);
    check("handover_bubble", 32'(arb_if.gnt), 32'h0);
    step(4'b0100, 1'b0);
    check("handover_gnt", 32'(arb_if.gnt), 32'h4);

    // Reset in the middle of the 0100 grant.
    step(4'b0100, 1'b1);
    check("midrst_gnt",   32'(arb_if.gnt),       32'h0);
    check("midrst_token", 32'(arb_if.token),     32'h1);
    check("midrst_valid", 32'(arb_if.gnt_valid), 32'h0);

    // Randomized requests with some persistence, occasional reset.
    rq = '0;
    for (int k = 0; k < 2000; k++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(3) == 0) rq[b] = ~rq[b];
      end
      step(rq, ($urandom_range(99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
